// File: rtl/ula_controlador.sv
// ula_controlador
// ---------------------------------------------------------------------------
// Sequencing controller for the 4-bit ULA datapath. A start request in IDLE
// registers operands, carry-in and operation selector, drives them to the
// ULA, waits LATENCIA settle cycles, then captures the 8-bit ULA result and
// pulses done for one cycle. In accumulate mode operand A is taken from the
// low nibble of the previous result, so operations can be chained.
//
// Handshake: start is a level request that is sampled only while the FSM is
// in IDLE. The edge that accepts it raises busy; requests seen while busy are
// dropped, never queued. busy falls on the edge that leaves DONE, and done is
// high for exactly the single cycle spent in DONE.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start                 operation request (sampled in IDLE only)
//   op_in[2:0]            operation code (111 and div-by-zero are errors)
//   a_in, b_in [3:0]      operands from switches
//   cin_in                carry-in from switch
//   acc_en                operand A comes from acc[3:0] when 1
//   clr_acc               synchronous accumulator clear, any edge
//   resultado_ula[7:0]    ULA mux output
//   a, b, cin, seletor    registered ULA drive
//   resultado[7:0]        last captured result
//   acc[7:0]              accumulator
//   busy, done            status / one-cycle completion pulse
//   erro, estouro         last-operation error / result > 15
//   estado_dbg[1:0]       current FSM state for observation
// ---------------------------------------------------------------------------
module ula_controlador #(
  parameter int unsigned LATENCIA = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op_in,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic       cin_in,
  input  logic       acc_en,
  input  logic       clr_acc,
  input  logic [7:0] resultado_ula,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       cin,
  output logic [2:0] seletor,
  output logic [7:0] resultado,
  output logic [7:0] acc,
  output logic       busy,
  output logic       done,
  output logic       erro,
  output logic       estouro,
  output logic [1:0] estado_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ESPERA = 2'd1,
    DONE   = 2'd2
  } estado_t;

  // Counter start value: LATENCIA-1 reload so capture lands LATENCIA edges
  // after the accepting edge (legal LATENCIA is 1..15).
  localparam logic [3:0] CNT_INI = 4'(LATENCIA - 1);

  estado_t    estado_q, estado_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       cin_q, cin_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] res_q, res_d;
  logic [7:0] acc_q, acc_d;
  logic       erro_q, erro_d;
  logic       estouro_q, estouro_d;
  logic       op_erro;

  // Invalid opcode or division by zero: skip the ULA wait entirely.
  assign op_erro = (op_in == 3'b111) || ((op_in == 3'b110) && (b_in == 4'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= IDLE;
      cnt_q     <= 4'd0;
      a_q       <= 4'd0;
      b_q       <= 4'd0;
      cin_q     <= 1'b0;
      sel_q     <= 3'd0;
      res_q     <= 8'd0;
      acc_q     <= 8'd0;
      erro_q    <= 1'b0;
      estouro_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      sel_q     <= sel_d;
      res_q     <= res_d;
      acc_q     <= acc_d;
      erro_q    <= erro_d;
      estouro_q <= estouro_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    sel_d     = sel_q;
    res_d     = res_q;
    acc_d     = acc_q;
    erro_d    = erro_q;
    estouro_d = estouro_q;

    case (estado_q)
      IDLE: begin
        if (start) begin
          a_d   = acc_en ? acc_q[3:0] : a_in;
          b_d   = b_in;
          cin_d = cin_in;
          sel_d = op_in;
          if (op_erro) begin
            res_d     = 8'd0;
            erro_d    = 1'b1;
            estouro_d = 1'b0;
            estado_d  = DONE;
          end else begin
            cnt_d    = CNT_INI;
            estado_d = ESPERA;
          end
        end
      end
      ESPERA: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_d     = resultado_ula;
          acc_d     = resultado_ula;
          erro_d    = 1'b0;
          estouro_d = (resultado_ula > 8'd15);
          estado_d  = DONE;
        end
      end
      DONE: begin
        estado_d = IDLE;
      end
      default: begin
        estado_d = IDLE;
      end
    endcase

    // Clear has priority over a coinciding capture for acc only.
    if (clr_acc) begin
      acc_d = 8'd0;
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign cin        = cin_q;
  assign seletor    = sel_q;
  assign resultado  = res_q;
  assign acc        = acc_q;
  assign erro       = erro_q;
  assign estouro    = estouro_q;
  assign busy       = (estado_q != IDLE);
  assign done       = (estado_q == DONE);
  assign estado_dbg = estado_q;

endmodule

// File: tb/tb_ula_controlador.sv
module tb_ula_controlador;

  localparam int LAT = 2;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] op_in;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic       cin_in;
  logic       acc_en;
  logic       clr_acc;
  logic [7:0] resultado_ula;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [2:0] seletor;
  logic [7:0] resultado;
  logic [7:0] acc;
  logic       busy;
  logic       done;
  logic       erro;
  logic       estouro;
  logic [1:0] estado_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  // {erro, estouro, resultado[7:0], acc[7:0]}
  logic [17:0] exp_q[$];
  logic [7:0]  exp_acc;

  ula_controlador #(.LATENCIA(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op_in(op_in), .a_in(a_in),
    .b_in(b_in), .cin_in(cin_in), .acc_en(acc_en), .clr_acc(clr_acc),
    .resultado_ula(resultado_ula), .a(a), .b(b), .cin(cin), .seletor(seletor),
    .resultado(resultado), .acc(acc), .busy(busy), .done(done), .erro(erro),
    .estouro(estouro), .estado_dbg(estado_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ULA model driven by the controller's registered outputs.
  function automatic logic [7:0] ula_fn(input logic [2:0] op, input logic [3:0] x,
                                        input logic [3:0] y, input logic c);
    logic [7:0] xe, ye;
    xe = {4'b0, x};
    ye = {4'b0, y};
    case (op)
      3'b000:  return xe + ye + {7'b0, c};
      3'b001:  return xe - ye;
      3'b010:  return xe & ye;
      3'b011:  return xe | ye;
      3'b100:  return xe * ye;
      3'b101:  return xe ^ ye;
      3'b110:  return (y != 4'd0) ? (xe / ye) : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  assign resultado_ula = ula_fn(seletor, a, b, cin);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Driver: one operation from IDLE to completion, checked through the queue.
  // exp_res is the result the ULA must return for the intended operands.
  task automatic do_op(input logic [2:0] op, input logic [3:0] ai, input logic [3:0] bi,
                       input logic ci, input logic ae, input logic [7:0] exp_res,
                       input logic clr_cap, input logic stray);
    logic        err;
    logic [3:0]  a_exp;
    logic [7:0]  new_acc;
    logic [17:0] e;
    int          lat_exp;
    int          n;
    int          busy_cnt;
    int          pulses;
    err     = (op == 3'b111) || ((op == 3'b110) && (bi == 4'd0));
    a_exp   = ae ? exp_acc[3:0] : ai;
    new_acc = err ? exp_acc : (clr_cap ? 8'd0 : exp_res);
    lat_exp = err ? 0 : LAT;
    exp_q.push_back({err, (!err && exp_res > 8'd15), (err ? 8'd0 : exp_res), new_acc});

    @(negedge clk);
    start = 1'b1; op_in = op; a_in = ai; b_in = bi; cin_in = ci; acc_en = ae;
    @(negedge clk);
    start = 1'b0;
    check("drive_a", a, a_exp);
    check("drive_b", b, bi);
    check("drive_cin", cin, ci);
    check("drive_sel", seletor, op);
    check("busy_after_accept", busy, 1);

    n = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_cnt++;
      start   = (stray && n == 0);
      if (stray && n == 0) op_in = op ^ 3'b011;
      clr_acc = (clr_cap && n == lat_exp - 1);
      @(negedge clk);
      n++;
    end
    start   = 1'b0;
    clr_acc = 1'b0;
    check("done_seen", done, 1);
    if (done === 1'b1) begin
      if (busy === 1'b1) busy_cnt++;
      check("done_latency", n, lat_exp);
      check("busy_cycles", busy_cnt, lat_exp + 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("erro", erro, e[17]);
        check("estouro", estouro, e[16]);
        check("resultado", resultado, e[15:8]);
        check("acc", acc, e[7:0]);
      end
    end
    check("sel_held", seletor, op);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_released", busy, 0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("no_extra_done", pulses, 0);
    check("outputs_hold", resultado, err ? 8'd0 : exp_res);
    exp_acc = new_acc;
  endtask

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; op_in = 3'd0; a_in = 4'd0; b_in = 4'd0;
    cin_in = 1'b0; acc_en = 1'b0; clr_acc = 1'b0; exp_acc = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_cin", cin, 0);
    check("rst_sel", seletor, 0);
    check("rst_resultado", resultado, 0);
    check("rst_acc", acc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_erro", erro, 0);
    check("rst_estouro", estouro, 0);

    // Basic soma 5+3+1
    do_op(3'b000, 4'd5, 4'd3, 1'b1, 1'b0, 8'd9, 1'b0, 1'b0);
    // Error paths: div by zero and invalid opcode leave acc alone
    do_op(3'b110, 4'd2, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    do_op(3'b111, 4'd4, 4'd4, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

    // Accumulate chain
    @(negedge clk); clr_acc = 1'b1;
    @(negedge clk); clr_acc = 1'b0;
    exp_acc = 8'd0;
    check("clr_acc", acc, 0);
    do_op(3'b000, 4'd7, 4'd0, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0);
    do_op(3'b000, 4'd15, 4'd4, 1'b0, 1'b1, 8'd11, 1'b0, 1'b0);
    do_op(3'b100, 4'd9, 4'd3, 1'b0, 1'b1, 8'd33, 1'b0, 1'b0);
    // Feedback truncates 33 to its low nibble 1
    do_op(3'b000, 4'd0, 4'd2, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0);

    // Stray start during ESPERA is ignored
    do_op(3'b000, 4'd2, 4'd3, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1);

    // Remaining operations
    do_op(3'b001, 4'd9, 4'd4, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0);
    do_op(3'b010, 4'hC, 4'hA, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0);
    do_op(3'b011, 4'hC, 4'hA, 1'b0, 1'b0, 8'h0E, 1'b0, 1'b0);
    do_op(3'b101, 4'hC, 4'hA, 1'b0, 1'b0, 8'h06, 1'b0, 1'b0);
    do_op(3'b110, 4'd13, 4'd4, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0);

    // Reset mid-ESPERA aborts without a done pulse
    @(negedge clk);
    start = 1'b1; op_in = 3'b000; a_in = 4'd1; b_in = 4'd1; cin_in = 1'b0; acc_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_resultado", resultado, 0);
    check("abort_acc", acc, 0);
    check("abort_a", a, 0);
    exp_acc = 8'd0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("abort_no_done", pulses, 0);

    // clr_acc coinciding with capture: resultado captures, acc cleared
    do_op(3'b000, 4'd6, 4'd6, 1'b0, 1'b0, 8'd12, 1'b1, 1'b0);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_controlador.md
# ula_controlador

Sequencing controller for the 4-bit ULA datapath. It registers the operands, carry-in and 3-bit operation selector on a start request and drives them to the ULA. It waits a fixed settling time, captures the 8-bit result and reports completion with a one-cycle pulse. An optional accumulate mode feeds the previous result back as operand A, so chained operations can run from the board switches without re-entering values.

## Interface
- LATENCIA, 2, settle cycles between driving ULA inputs and capturing `resultado_ula`; legal range 1..15.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op_in  input  3  operation code: 000 soma, 001 sub, 010 AND, 011 OR, 100 mult, 101 XOR, 110 div, 111 invalid.
- a_in  input  4  operand A from switches.
- b_in  input  4  operand B from switches.
- cin_in  input  1  carry-in from switch.
- acc_en  input  1  sampled with start; 1 = operand A comes from `acc[3:0]`.
- clr_acc  input  1  synchronous clear of the accumulator.
- resultado_ula  input  8  ULA mux output.
- a, b  output  4 each  registered operands to ULA.
- cin  output  1  registered carry-in to ULA.
- seletor  output  3  registered operation select to ULA.
- resultado  output  8  captured result, held until the next completion.
- acc  output  8  accumulator.
- busy  output  1  high from the accepting edge until DONE exits.
- done  output  1  one-cycle completion pulse.
- erro  output  1  error of the last completed operation.
- estouro  output  1  last captured result exceeded 15, so the feedback to A is truncated.

## Operation
- States: IDLE, ESPERA, DONE. The encoding is free.
- IDLE with start=1 (edge k) loads the following:
  - a ← acc_en ? acc[3:0] : a_in.
  - b ← b_in; cin ← cin_in; seletor ← op_in.
  - busy ← 1.
- Error check at edge k: op_in=111, or op_in=110 with b_in=0, is an error.
  - On error: state → DONE, resultado ← 0, erro ← 1, estouro ← 0. acc is unchanged.
  - Otherwise: cnt ← LATENCIA−1, state → ESPERA.
- ESPERA: when cnt≠0, cnt decrements each edge. When cnt=0, the edge does the following:
  - resultado ← resultado_ula; acc ← resultado_ula.
  - erro ← 0; estouro ← (resultado_ula > 15).
  - state → DONE.
- DONE: done=1 for exactly one cycle. On the next edge, state → IDLE and busy ← 0.
- start in ESPERA or DONE is ignored and not queued.
- Operand/selector outputs hold their values after completion until the next accepted start.
- clr_acc=1 sets acc ← 0 on any edge. If it coincides with a capture edge, clr_acc wins for acc; resultado still captures.
- Arithmetic: no arithmetic inside the block. Feedback uses acc[3:0] only; bits 7:4 are reported through estouro.

## Timing
- Reset values: state IDLE, cnt 0, and all of the following at 0: a, b, cin, seletor, resultado, acc, busy, done, erro, estouro.
- Normal path: start accepted at edge k; capture at edge k+LATENCIA; done high during the cycle after that edge; busy low after edge k+LATENCIA+1.
- Error path: done is high during the cycle after edge k; no ULA wait.
- Back-to-back: the earliest next accept is the edge at which state = IDLE again (start held high is re-accepted then).
- reset during ESPERA/DONE: aborts immediately; no done pulse; all outputs return to reset values.

## Test plan
- Reset, then LATENCIA=2, start, op_in=000, a_in=5, b_in=3, cin_in=1, with the ULA model returning 9. Required: capture at k+2, done pulse 1 cycle, resultado=9, erro=0, busy high for 3 cycles.
- op_in=110, b_in=0 → done 1 cycle after accept, erro=1, resultado=0, acc unchanged.
- Accumulate chain: acc=0, clr_acc, then soma a_in=7 (acc_en=0) → acc=7. Next, acc_en=1, soma b_in=4 → a driven 7, result 11. Next, mult b_in=3 → a driven 11, result 33, estouro=1.
- start pulsed during ESPERA with different op_in → ignored, seletor unchanged, single done.
- reset asserted mid-ESPERA → next cycle busy=0, done never pulses, resultado=0. Then clr_acc together with a capture edge → acc=0, resultado=captured value.
